decode_stage: RTL and testbench

Instruction decode stage directly upstream of the 16 x 16-bit register file. It accepts 16-bit instructions over a valid/ready handshake and holds each one in an IF/ID register. It drives the regfile read addresses and checks a pending-write scoreboard for RAW/WAW hazards. When clear, it issues opcode, destination and both operands into a registered ID/EX output with its own valid/ready handshake.

---
 rtl/decode_stage_pkg.sv | 35 +++
 rtl/decode_stage_if.sv | 29 ++
 rtl/decode_stage_scoreboard.sv | 34 +++
 rtl/decode_stage.sv | 80 ++++++++
 tb/tb_decode_stage.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode map, instruction field positions and operand-usage classification.
package decode_stage_pkg;
    typedef logic [3:0] regAddr_t;
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_ALU_FIRST = 4'h1;
    localparam logic [3:0] OP_ALU_LAST = 4'h7;
    localparam logic [3:0] OP_LDI = 4'h8;
    localparam logic [3:0] OP_STORE = 4'h9;
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB = 11;
    localparam int RD_LSB = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    function automatic logic isAlu(input logic [3:0] op);
        return op >= OP_ALU_FIRST && op <= OP_ALU_LAST;
    endfunction

    function automatic logic usesRs1(input logic [3:0] op);
        return isAlu(op) || op == OP_STORE;
    endfunction

    function automatic logic usesRs2(input logic [3:0] op);
        return isAlu(op) || op == OP_STORE;
    endfunction

    function automatic logic writesRd(input logic [3:0] op);
        return isAlu(op) || op == OP_LDI;
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: instruction in, regfile read, ID/EX out and writeback signals of the decode stage.
interface decode_stage_if;
    logic inValid;
    logic inReady;
    logic [15:0] instr;
    logic [3:0] read1;
    logic [3:0] read2;
    logic [15:0] dataRead1;
    logic [15:0] dataRead2;
    logic outValid;
    logic outReady;
    logic [3:0] outOpcode;
    logic [3:0] outWrite;
    logic outWriteEn;
    logic [15:0] outA;
    logic [15:0] outB;
    logic wbValid;
    logic [3:0] wbAddr;

    modport master (
        output inValid, instr, dataRead1, dataRead2, outReady, wbValid, wbAddr,
        input inReady, read1, read2, outValid, outOpcode, outWrite, outWriteEn, outA, outB
    );

    modport slave (
        input inValid, instr, dataRead1, dataRead2, outReady, wbValid, wbAddr,
        output inReady, read1, read2, outValid, outOpcode, outWrite, outWriteEn, outA, outB
    );
endinterface

// File: rtl/decode_stage_scoreboard.sv
// decode_stage_scoreboard: one pending-write bit per register; a set beats a clear on the same index.
module decode_stage_scoreboard
    import decode_stage_pkg::*;
(
    input logic Clk,
    input logic Reset,
    input logic setEn,
    input regAddr_t setAddr,
    input logic clrEn,
    input regAddr_t clrAddr,
    input regAddr_t chk1Addr,
    input regAddr_t chk2Addr,
    input regAddr_t chkDAddr,
    output logic pend1,
    output logic pend2,
    output logic pendD
);
    logic [15:0] pending;
    logic [15:0] setMask;
    logic [15:0] clrMask;

    always_comb begin
        setMask = setEn ? 16'(1) << setAddr : '0;
        clrMask = clrEn ? 16'(1) << clrAddr : '0;
        pend1 = pending[chk1Addr];
        pend2 = pending[chk2Addr];
        pendD = pending[chkDAddr];
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) pending <= '0;
        else pending <= (pending & ~clrMask) | setMask;
    end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: IF/ID hold register checked against the pending-write scoreboard, issuing into a registered ID/EX slot.
module decode_stage
    import decode_stage_pkg::*;
(
    input logic Clk,
    input logic Reset,
    decode_stage_if.slave bus
);
    logic heldValid;
    logic [15:0] heldInstr;
    logic [3:0] opcode;
    regAddr_t rd;
    regAddr_t rs1;
    regAddr_t rs2;
    logic pend1;
    logic pend2;
    logic pendD;
    logic hazard;
    logic issue;

    always_comb begin
        opcode = heldInstr[OPC_MSB:OPC_LSB];
        rd = heldInstr[RD_MSB:RD_LSB];
        rs1 = heldInstr[RS1_MSB:RS1_LSB];
        rs2 = heldInstr[RS2_MSB:RS2_LSB];
        hazard = (usesRs1(opcode) && pend1) || (usesRs2(opcode) && pend2) || (writesRd(opcode) && pendD);
        issue = heldValid && !hazard && (!bus.outValid || bus.outReady);
        bus.inReady = !heldValid || issue;
        bus.read1 = rs1;
        bus.read2 = rs2;
    end

    decode_stage_scoreboard sb (
        .Clk(Clk),
        .Reset(Reset),
        .setEn(issue && writesRd(opcode)),
        .setAddr(rd),
        .clrEn(bus.wbValid),
        .clrAddr(bus.wbAddr),
        .chk1Addr(rs1),
        .chk2Addr(rs2),
        .chkDAddr(rd),
        .pend1(pend1),
        .pend2(pend2),
        .pendD(pendD)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            heldValid <= 1'b0;
            heldInstr <= '0;
        end else if (bus.inValid && bus.inReady) begin
            heldValid <= 1'b1;
            heldInstr <= bus.instr;
        end else if (issue) begin
            heldValid <= 1'b0;
        end
    end

    // LDI carries its immediate in the rs1/rs2 field, so its operands bypass the regfile.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bus.outValid <= 1'b0;
            bus.outOpcode <= '0;
            bus.outWrite <= '0;
            bus.outWriteEn <= 1'b0;
            bus.outA <= '0;
            bus.outB <= '0;
        end else if (issue) begin
            bus.outValid <= 1'b1;
            bus.outOpcode <= opcode;
            bus.outWrite <= rd;
            bus.outWriteEn <= writesRd(opcode);
            bus.outA <= (opcode == OP_LDI) ? '0 : bus.dataRead1;
            bus.outB <= (opcode == OP_LDI) ? {8'h00, heldInstr[IMM_MSB:IMM_LSB]} : bus.dataRead2;
        end else if (bus.outReady) begin
            bus.outValid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed plus randomized stimulus; a monitor checks every issued instruction against a queued reference.
module tb_decode_stage;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    decode_stage_if bus();
    decode_stage dut (.Clk(Clk), .Reset(Reset), .bus(bus));

    logic [15:0] regs [16];
    assign bus.dataRead1 = regs[bus.read1];
    assign bus.dataRead2 = regs[bus.read2];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        logic [3:0] op;
        logic [3:0] rd;
        logic we;
        logic [15:0] a;
        logic [15:0] b;
    } exp_t;

    exp_t expQ[$];
    logic [3:0] wbQ[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] i);
        exp_t e;
        int op;
        op = int'(i[15:12]);
        e.instr = i;
        e.op = i[15:12];
        e.rd = i[11:8];
        e.we = op >= 1 && op <= 8;
        e.a = (op == 8) ? 16'h0000 : regs[i[7:4]];
        e.b = (op == 8) ? {8'h00, i[7:0]} : regs[i[3:0]];
        return e;
    endfunction

    function automatic bit readsRegs(input logic [15:0] i);
        int op;
        op = int'(i[15:12]);
        return (op >= 1 && op <= 7) || op == 9;
    endfunction

    // Monitor: reference scoreboard of outstanding writes plus in-order expected outputs.
    logic prevValid = 0, prevTake = 0, prevStall = 0, lastWbV = 0;
    logic [3:0] lastWbA = 0;
    logic [15:0] outst = 0, nxt;
    logic [40:0] snap = 0;
    exp_t e;

    always @(negedge Clk) begin
        if (Reset) begin
            expQ.delete();
            wbQ.delete();
            prevValid = 0;
            prevTake = 0;
            prevStall = 0;
            lastWbV = 0;
            outst = 0;
        end else begin
            nxt = outst;
            if (lastWbV) nxt[lastWbA] = 1'b0;
            if (bus.outValid && (!prevValid || prevTake)) begin
                chk("issue_queued", 64'(expQ.size() != 0), 1);
                if (expQ.size() != 0) begin
                    e = expQ[0];
                    chk("issue_opcode", bus.outOpcode, e.op);
                    chk("issue_write", bus.outWrite, e.rd);
                    chk("issue_we", bus.outWriteEn, e.we);
                    chk("issue_a", bus.outA, e.a);
                    chk("issue_b", bus.outB, e.b);
                    chk("issue_hazard_free", 64'((readsRegs(e.instr) && (outst[e.instr[7:4]] || outst[e.instr[3:0]])) || (e.we && outst[e.rd])), 0);
                    if (e.we) nxt[e.rd] = 1'b1;
                end
            end
            if (prevStall) chk("stall_stable", {bus.outValid, bus.outOpcode, bus.outWrite, bus.outWriteEn, bus.outA, bus.outB}, {1'b1, snap});
            chk("pending", dut.sb.pending, nxt);
            outst = nxt;
            prevValid = bus.outValid;
            prevTake = bus.outValid && bus.outReady;
            prevStall = bus.outValid && !bus.outReady;
            snap = {bus.outOpcode, bus.outWrite, bus.outWriteEn, bus.outA, bus.outB};
            if (prevTake && expQ.size() != 0) begin
                if (expQ[0].we) wbQ.push_back(expQ[0].rd);
                void'(expQ.pop_front());
            end
            if (bus.inValid && bus.inReady) expQ.push_back(model(bus.instr));
            lastWbV = bus.wbValid;
            lastWbA = bus.wbAddr;
        end
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic send(input logic [15:0] i);
        int n;
        n = 0;
        bus.inValid = 1'b1;
        bus.instr = i;
        @(negedge Clk);
        while (!bus.inReady && n < 50) begin
            n++;
            @(negedge Clk);
        end
        if (!bus.inReady) chk("send_accept", bus.inReady, 1);
        tick();
    endtask

    task automatic wbPulse(input logic [3:0] a);
        bus.wbValid = 1'b1;
        bus.wbAddr = a;
        tick();
        bus.wbValid = 1'b0;
    endtask

    task automatic chkResetValues();
        chk("rst_inReady", bus.inReady, 1);
        chk("rst_outValid", bus.outValid, 0);
        chk("rst_outWriteEn", bus.outWriteEn, 0);
        chk("rst_outOpcode", bus.outOpcode, 0);
        chk("rst_outWrite", bus.outWrite, 0);
        chk("rst_outA", bus.outA, 0);
        chk("rst_outB", bus.outB, 0);
        chk("rst_read1", bus.read1, 0);
        chk("rst_read2", bus.read2, 0);
        chk("rst_pending", dut.sb.pending, 0);
    endtask

    logic accNext = 0;

    initial begin
        bus.inValid = 0;
        bus.instr = 0;
        bus.outReady = 0;
        bus.wbValid = 0;
        bus.wbAddr = 0;
        for (int i = 0; i < 16; i++) regs[i] = 16'($urandom_range(1, 16'hFFFF));
        regs[1] = 16'h0005;
        regs[2] = 16'h000A;
        repeat (2) @(negedge Clk);
        chkResetValues();
        tick();
        Reset = 0;
        bus.outReady = 1;

        // basic ALU issue and latency
        send(16'h1312);
        bus.inValid = 0;
        @(negedge Clk);
        chk("t1_read1", bus.read1, 1);
        chk("t1_read2", bus.read2, 2);
        chk("t1_not_yet", bus.outValid, 0);
        @(negedge Clk);
        chk("t1_outValid", bus.outValid, 1);
        chk("t1_outA", bus.outA, 16'h0005);
        chk("t1_outB", bus.outB, 16'h000A);
        chk("t1_outWrite", bus.outWrite, 3);
        chk("t1_pend3", dut.sb.pending[3], 1);
        tick();
        wbPulse(3);

        // RAW stall released by writeback
        send(16'h1312);
        send(16'h1435);
        bus.inValid = 0;
        @(negedge Clk);
        chk("raw_stall_inReady", bus.inReady, 0);
        chk("raw_read1", bus.read1, 3);
        tick();
        @(negedge Clk);
        chk("raw_still_stalled", bus.inReady, 0);
        chk("raw_no_out", bus.outValid, 0);
        tick();
        wbPulse(3);
        @(negedge Clk);
        chk("raw_wb_cycle_no_out", bus.outValid, 0);
        @(negedge Clk);
        chk("raw_issued", bus.outValid, 1);
        chk("raw_outWrite", bus.outWrite, 4);
        chk("raw_outA", bus.outA, regs[3]);
        tick();
        wbPulse(4);

        // LDI ignores pending r15/r10
        send(16'h1F00);
        send(16'h1A00);
        send(16'h8DFA);
        bus.inValid = 0;
        @(negedge Clk);
        @(negedge Clk);
        chk("ldi_opcode", bus.outOpcode, 8);
        chk("ldi_outA", bus.outA, 16'h0000);
        chk("ldi_outB", bus.outB, 16'h00FA);
        chk("ldi_outWrite", bus.outWrite, 13);
        chk("ldi_outWriteEn", bus.outWriteEn, 1);
        chk("ldi_pending", dut.sb.pending, 16'hA400);
        tick();
        wbPulse(15);
        wbPulse(10);
        wbPulse(13);

        // backpressure
        bus.outReady = 0;
        bus.inValid = 1;
        bus.instr = 16'h2612;
        tick();
        bus.instr = 16'h3734;
        tick();
        bus.instr = 16'h4859;
        @(negedge Clk);
        chk("bp_first_out", bus.outWrite, 6);
        chk("bp_inReady", bus.inReady, 0);
        chk("bp_second_held", bus.read1, 3);
        tick();
        @(negedge Clk);
        chk("bp_first_stable", bus.outA, regs[1]);
        chk("bp_inReady2", bus.inReady, 0);
        tick();
        bus.outReady = 1;
        tick();
        bus.inValid = 0;
        @(negedge Clk);
        chk("bp_drain2", bus.outWrite, 7);
        chk("bp_third_held", bus.read1, 5);
        @(negedge Clk);
        chk("bp_drain3", bus.outWrite, 8);
        chk("bp_drain3_valid", bus.outValid, 1);
        @(negedge Clk);
        chk("bp_empty", bus.outValid, 0);
        tick();
        wbPulse(6);
        wbPulse(7);
        wbPulse(8);

        // set and clear on r5 in the same cycle
        bus.outReady = 0;
        bus.inValid = 1;
        bus.instr = 16'h1501;
        tick();
        bus.inValid = 0;
        bus.wbValid = 1;
        bus.wbAddr = 5;
        tick();
        bus.wbValid = 0;
        @(negedge Clk);
        chk("sim_pend5", dut.sb.pending[5], 1);
        chk("sim_outWrite", bus.outWrite, 5);

        // asynchronous reset mid-operation
        #2 Reset = 1;
        #1 chkResetValues();
        @(negedge Clk);
        tick();
        Reset = 0;
        bus.outReady = 1;
        send(16'h9012);
        bus.inValid = 0;
        @(negedge Clk);
        @(negedge Clk);
        chk("st_outValid", bus.outValid, 1);
        chk("st_opcode", bus.outOpcode, 9);
        chk("st_outWriteEn", bus.outWriteEn, 0);
        chk("st_pending", dut.sb.pending, 0);
        tick();

        // randomized traffic with random backpressure and writeback delay
        for (int c = 0; c < 1000; c++) begin
            if (!bus.inValid || accNext) begin
                bus.inValid = $urandom_range(0, 3) != 0;
                bus.instr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7))};
            end
            bus.outReady = $urandom_range(0, 3) != 0;
            if (wbQ.size() != 0 && $urandom_range(0, 1) == 1) begin
                bus.wbValid = 1;
                bus.wbAddr = wbQ.pop_front();
            end else begin
                bus.wbValid = 0;
            end
            @(negedge Clk);
            accNext = bus.inValid && bus.inReady;
            tick();
        end
        bus.inValid = 0;
        bus.outReady = 1;
        for (int c = 0; c < 300 && (expQ.size() != 0 || wbQ.size() != 0); c++) begin
            if (wbQ.size() != 0) begin
                bus.wbValid = 1;
                bus.wbAddr = wbQ.pop_front();
            end else begin
                bus.wbValid = 0;
            end
            @(negedge Clk);
            tick();
        end
        bus.wbValid = 0;
        @(negedge Clk);
        chk("drain_expQ", 64'(expQ.size()), 0);
        chk("drain_pending", dut.sb.pending, 0);
        chk("drain_outValid", bus.outValid, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1);
    end
endmodule
